// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter that owns the select of a shared N-to-1 mux.
//   Grants are one-hot and registered. Each tenure is bounded by MAX_HOLD cycles,
//   where 0 means unlimited. Every handover passes through one dead GAP cycle with
//   all grants low, so the old and new sources are never both enabled
//   (break-before-make).
//
// Request/grant protocol:
//   A requester raises i_req[i] and keeps it high for as long as it wants the mux.
//   o_gnt[i] rises on the edge after the request is seen, provided the arbiter is
//   free. It stays high until the requester drops i_req[i] or the tenure limit is
//   reached. o_gnt clears on the edge on which either condition is observed.
//   A requester preempted by the limit may keep i_req high. It is then re-arbitrated
//   at the lowest priority.
//   o_sel always names the current owner, or the last owner when no grant is active.
//   o_sel changes only on the edge that enters GRANT.
module mux_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 i_clock,
  input  logic                 i_n_reset,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_sel,
  output logic                 o_busy,
  output logic [1:0]           o_state
);

  localparam int SEL_W = $clog2(N);
  // The counter only has to reach MAX_HOLD-1. Keep at least one bit so the
  // unlimited and MAX_HOLD=1 builds still elaborate.
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 1) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam bit HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_last;
  logic [CNT_W-1:0]  r_count;
  logic [N-1:0]      r_gnt;

  logic              w_found;
  logic [SEL_W-1:0]  w_winner;
  logic [SEL_W-1:0]  w_idx;
  logic [N-1:0]      w_winner_oh;
  logic              w_exit;
  logic              w_arb;

  // Round-robin search. Start just after the last owner and wrap at N-1, so the
  // last owner itself is visited last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = r_last;
    for (int k = 0; k < N; k++) begin
      w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + SEL_W'(1);
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // One-hot decode of the winner, loaded into the grant register.
  always_comb begin
    w_winner_oh           = '0;
    w_winner_oh[w_winner] = 1'b1;
  end

  // End of tenure: the owner let go, or the hold limit has been reached. When both
  // happen in the same cycle the result is still a single GAP.
  always_comb begin
    w_exit = !i_req[r_sel] || (HOLD_LIMITED && (r_count == HOLD_LAST));
  end

  // A new owner may only be chosen when nobody holds the mux.
  always_comb begin
    w_arb = (r_state != ST_GRANT) && w_found;
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_next_state = ST_GRANT;
      end
      ST_GRANT: begin
        if (w_exit) w_next_state = ST_GAP;
      end
      ST_GAP: begin
        w_next_state = w_found ? ST_GRANT : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Owner, pointer, tenure counter and grant register. These update together with
  // the state so that the grant never disagrees with sel.
  always_ff @(posedge i_clock or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_sel   <= '0;
      r_last  <= LAST_IDX;
      r_count <= '0;
      r_gnt   <= '0;
    end else if (w_arb) begin
      r_sel   <= w_winner;
      r_last  <= w_winner;
      r_count <= '0;
      r_gnt   <= w_winner_oh;
    end else if (r_state == ST_GRANT) begin
      if (w_exit) begin
        r_gnt <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Outputs come straight from registers, so they carry no decode glitches.
  always_comb begin
    o_gnt   = r_gnt;
    o_sel   = r_sel;
    o_busy  = |r_gnt;
    o_state = r_state;
  end

endmodule
